// File: rtl/n64_save_pkg.sv
// n64_save_pkg: shared save-region constants, upload FSM states and halfword select
//   Optional macro SAVE_UPLOAD_BYTESWAP_EN: byte-swap every returned halfword.
package n64_save_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
   localparam logic [7:0]  SAVE_INDEX_DEF = 8'd2;
   localparam logic [26:0] SAVE_BASE_DEF  = 27'h2000000;
   localparam logic [26:0] SAVE_BYTES_DEF = 27'd131072;
   // Low half at addr[1]=0, high half at addr[1]=1, matching the download packer.
   function automatic logic [15:0] half_sel(input logic [31:0] w, input logic hi);
      logic [15:0] h;
      h = hi ? w[31:16] : w[15:0];
`ifdef SAVE_UPLOAD_BYTESWAP_EN
      return {h[7:0], h[15:8]};
`else
      return h;
`endif
   endfunction
endpackage

// File: rtl/save_upload_reader.sv
// save_upload_reader: streams a save region from SDRAM to hps_io as 16-bit upload reads
//   clk1x, reset (async, active-high)
//   ioctl_upload/index/addr/rd in, ioctl_din/ioctl_wait out   : hps_io upload side
//   mem_req/rnw/addr out, mem_dout/mem_ready in              : sdram read channel
//   active out                                               : upload selected
//   Optional macro SAVE_UPLOAD_BYTESWAP_EN (see n64_save_pkg::half_sel).
module save_upload_reader
   import n64_save_pkg::*;
#(
   parameter logic [7:0]  UPLOAD_INDEX = SAVE_INDEX_DEF,
   parameter logic [26:0] SAVE_BASE    = SAVE_BASE_DEF,
   parameter logic [26:0] SAVE_BYTES   = SAVE_BYTES_DEF
) (
   input  logic        clk1x,
   input  logic        reset,
   input  logic        ioctl_upload,
   input  logic [7:0]  ioctl_index,
   input  logic [26:0] ioctl_addr,
   input  logic        ioctl_rd,
   output logic [15:0] ioctl_din,
   output logic        ioctl_wait,
   output logic        mem_req,
   output logic        mem_rnw,
   output logic [26:0] mem_addr,
   input  logic [31:0] mem_dout,
   input  logic        mem_ready,
   output logic        active
);
   state_t state, state_n;
   logic [31:0] data_q, eff_word;
   logic [24:0] tag, f_tag, q_tag, dem_tag, rd_tag, eff_tag, issue_tag;
   logic valid, q_v, dem, dem_hi;
   logic sel, rise, rd, in_range, fill, eff_valid, hit, miss, idle_eff, pf, issue, set_q;
   assign mem_rnw = 1'b1;
   always_comb begin
      sel = ioctl_upload && ioctl_index == UPLOAD_INDEX;
      rise = sel && !active;
      rd = ioctl_rd && sel;
      rd_tag = ioctl_addr[26:2];
      in_range = ioctl_addr < SAVE_BYTES;
      // A completing fetch is folded into the buffer view before the hit check.
      fill = mem_ready && state == FETCH && sel;
      eff_valid = fill || (valid && !rise);
      eff_tag = fill ? f_tag : tag;
      eff_word = fill ? mem_dout : data_q;
      hit = rd && in_range && eff_valid && eff_tag == rd_tag;
      miss = rd && in_range && !hit;
      idle_eff = sel && (state == IDLE || fill);
      pf = hit && ioctl_addr[1] && ({rd_tag + 25'd1, 2'b00} < SAVE_BYTES);
      issue = idle_eff && (miss || q_v || pf || rise);
      issue_tag = miss ? rd_tag : q_v ? q_tag : pf ? rd_tag + 25'd1 : 25'd0;
      // Work that cannot start now (busy on another word, or draining) is queued.
      set_q = !idle_eff && ((miss && !(state == FETCH && f_tag == rd_tag)) || rise);
      state_n = issue ? FETCH
              : (state == DRAIN || (state == FETCH && !sel)) ? (mem_ready ? IDLE : DRAIN)
              : fill ? IDLE : state;
   end
   always_ff @(posedge clk1x or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk1x or posedge reset)
      if (reset) begin
         ioctl_din <= '0;
         ioctl_wait <= 1'b0;
         mem_req <= 1'b0;
         mem_addr <= '0;
         active <= 1'b0;
         data_q <= '0;
         tag <= '0;
         f_tag <= '0;
         q_tag <= '0;
         dem_tag <= '0;
         valid <= 1'b0;
         q_v <= 1'b0;
         dem <= 1'b0;
         dem_hi <= 1'b0;
      end else begin
         active <= sel;
         mem_req <= issue;
         valid <= eff_valid;
         if (issue) begin
            mem_addr <= SAVE_BASE + {issue_tag, 2'b00};
            f_tag <= issue_tag;
         end
         if (fill) begin
            data_q <= mem_dout;
            tag <= f_tag;
         end
         q_v <= sel && (set_q || (q_v && !issue));
         if (set_q) q_tag <= miss ? rd_tag : 25'd0;
         if (!sel) begin
            ioctl_wait <= 1'b0;
            dem <= 1'b0;
         end else if (fill && dem && dem_tag == f_tag) begin
            ioctl_din <= half_sel(mem_dout, dem_hi);
            ioctl_wait <= 1'b0;
            dem <= 1'b0;
         end
         if (rd && !in_range) ioctl_din <= 16'hFFFF;
         if (hit) ioctl_din <= half_sel(eff_word, ioctl_addr[1]);
         if (miss) begin
            ioctl_wait <= 1'b1;
            dem <= 1'b1;
            dem_tag <= rd_tag;
            dem_hi <= ioctl_addr[1];
         end
      end
endmodule

// File: tb/tb_save_upload_reader.sv
// tb_save_upload_reader: directed self-checking bench for save_upload_reader (SAVE_BYTES=8)
module tb_save_upload_reader;
   logic clk1x = 1'b0, reset = 1'b1, ioctl_upload = 1'b0, ioctl_rd = 1'b0, mem_ready = 1'b0;
   logic [7:0] ioctl_index = '0;
   logic [26:0] ioctl_addr = '0;
   logic [31:0] mem_dout = '0;
   logic [15:0] ioctl_din;
   logic ioctl_wait, mem_req, mem_rnw, active;
   logic [26:0] mem_addr, paddr;
   int vecs = 0, errs = 0, lat = 1, cnt = 0, reqs = 0, r0, n;
   logic stall_ok;

   save_upload_reader #(.SAVE_BYTES(27'd8)) dut (
      .clk1x(clk1x), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
      .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
      .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .mem_ready(mem_ready), .active(active));

   always #5 clk1x = ~clk1x;

   function automatic logic [15:0] h(input logic [15:0] x);
`ifdef SAVE_UPLOAD_BYTESWAP_EN
      return {x[7:0], x[15:8]};
`else
      return x;
`endif
   endfunction

   function automatic logic [31:0] word_at(input logic [26:0] a);
      logic [26:0] idx;
      idx = (a - 27'h2000000) >> 2;
      return idx == 0 ? 32'hAABBCCDD : idx == 1 ? 32'h11223344 : {16'hDEAD, idx[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_rd(input logic [26:0] a);
      ioctl_addr = a;
      ioctl_rd = 1'b1;
      @(negedge clk1x);
      ioctl_rd = 1'b0;
   endtask

   task automatic wait_ready();
      n = 0;
      while (mem_ready !== 1'b1 && n < 60) begin
         @(negedge clk1x);
         n++;
      end
      chk("ready_timeout", {31'd0, mem_ready}, 32'd1);
   endtask

   // SDRAM channel model: one outstanding read, ready 'lat' cycles after the request is seen.
   initial forever begin
      @(posedge clk1x);
      #1;
      mem_ready = 1'b0;
      if (cnt > 0) begin
         cnt--;
         if (cnt == 0) begin
            mem_ready = 1'b1;
            mem_dout = word_at(paddr);
         end
      end
      if (mem_req) begin
         reqs++;
         paddr = mem_addr;
         cnt = lat;
      end
   end

   initial begin
      repeat (2) @(negedge clk1x);
      chk("rst_din", {16'd0, ioctl_din}, 32'd0);
      chk("rst_wait", {31'd0, ioctl_wait}, 32'd0);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_addr", {5'd0, mem_addr}, 32'd0);
      chk("rst_active", {31'd0, active}, 32'd0);
      chk("rnw", {31'd0, mem_rnw}, 32'd1);
      reset = 1'b0;
      @(negedge clk1x);
      ioctl_index = 8'd2;
      ioctl_upload = 1'b1;
      @(negedge clk1x);
      chk("start_active", {31'd0, active}, 32'd1);
      chk("start_req", {31'd0, mem_req}, 32'd1);
      chk("start_addr", {5'd0, mem_addr}, 32'h2000000);
      @(negedge clk1x);
      chk("req_one_cycle", {31'd0, mem_req}, 32'd0);
      repeat (2) @(negedge clk1x);
      do_rd(27'd0);
      chk("seq0_din", {16'd0, ioctl_din}, {16'd0, h(16'hCCDD)});
      chk("seq0_wait", {31'd0, ioctl_wait}, 32'd0);
      chk("seq0_noreq", {31'd0, mem_req}, 32'd0);
      do_rd(27'd2);
      chk("seq2_din", {16'd0, ioctl_din}, {16'd0, h(16'hAABB)});
      chk("seq2_wait", {31'd0, ioctl_wait}, 32'd0);
      chk("pf_req", {31'd0, mem_req}, 32'd1);
      chk("pf_addr", {5'd0, mem_addr}, 32'h2000004);
      do_rd(27'd0);
      chk("oldword_din", {16'd0, ioctl_din}, {16'd0, h(16'hCCDD)});
      chk("oldword_wait", {31'd0, ioctl_wait}, 32'd0);
      do_rd(27'd4);
      chk("seq4_din", {16'd0, ioctl_din}, {16'd0, h(16'h3344)});
      chk("seq4_wait", {31'd0, ioctl_wait}, 32'd0);
      do_rd(27'd6);
      chk("seq6_din", {16'd0, ioctl_din}, {16'd0, h(16'h1122)});
      chk("seq6_wait", {31'd0, ioctl_wait}, 32'd0);
      chk("seq6_noreq", {31'd0, mem_req}, 32'd0);
      do_rd(27'd8);
      chk("range_din", {16'd0, ioctl_din}, 32'h0000FFFF);
      chk("range_wait", {31'd0, ioctl_wait}, 32'd0);
      repeat (3) @(negedge clk1x);
      chk("seq_reqs", reqs, 32'd2);
      lat = 20;
      do_rd(27'd0);
      chk("stall_wait", {31'd0, ioctl_wait}, 32'd1);
      chk("stall_req", {31'd0, mem_req}, 32'd1);
      chk("stall_addr", {5'd0, mem_addr}, 32'h2000000);
      stall_ok = 1'b1;
      n = 0;
      while (mem_ready !== 1'b1 && n < 60) begin
         if (ioctl_wait !== 1'b1) stall_ok = 1'b0;
         @(negedge clk1x);
         n++;
      end
      chk("stall_ready_seen", {31'd0, mem_ready}, 32'd1);
      chk("stall_wait_held", {31'd0, stall_ok & ioctl_wait}, 32'd1);
      @(negedge clk1x);
      chk("stall_din", {16'd0, ioctl_din}, {16'd0, h(16'hCCDD)});
      chk("stall_release", {31'd0, ioctl_wait}, 32'd0);
      chk("stall_reqs", reqs, 32'd3);
      do_rd(27'd4);
      chk("abort_wait_on", {31'd0, ioctl_wait}, 32'd1);
      ioctl_upload = 1'b0;
      @(negedge clk1x);
      chk("abort_wait_off", {31'd0, ioctl_wait}, 32'd0);
      chk("abort_active", {31'd0, active}, 32'd0);
      r0 = reqs;
      wait_ready();
      @(negedge clk1x);
      chk("drain_noreq", reqs, r0);
      chk("drain_req_low", {31'd0, mem_req}, 32'd0);
      do_rd(27'd0);
      chk("unsel_din", {16'd0, ioctl_din}, {16'd0, h(16'hCCDD)});
      chk("unsel_wait", {31'd0, ioctl_wait}, 32'd0);
      lat = 1;
      ioctl_upload = 1'b1;
      @(negedge clk1x);
      chk("restart_req", {31'd0, mem_req}, 32'd1);
      chk("restart_addr", {5'd0, mem_addr}, 32'h2000000);
      chk("restart_reqs", reqs, r0 + 1);
      repeat (3) @(negedge clk1x);
      do_rd(27'd2);
      chk("restart_din", {16'd0, ioctl_din}, {16'd0, h(16'hAABB)});
      repeat (3) @(negedge clk1x);
      do_rd(27'd0);
      chk("refill_miss_wait", {31'd0, ioctl_wait}, 32'd1);
      repeat (3) @(negedge clk1x);
      chk("refill_din", {16'd0, ioctl_din}, {16'd0, h(16'hCCDD)});
      lat = 10;
      do_rd(27'd4);
      chk("rstmid_wait_on", {31'd0, ioctl_wait}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_din", {16'd0, ioctl_din}, 32'd0);
      chk("arst_wait", {31'd0, ioctl_wait}, 32'd0);
      chk("arst_req", {31'd0, mem_req}, 32'd0);
      chk("arst_addr", {5'd0, mem_addr}, 32'd0);
      chk("arst_active", {31'd0, active}, 32'd0);
      ioctl_upload = 1'b0;
      @(negedge clk1x);
      reset = 1'b0;
      r0 = reqs;
      wait_ready();
      repeat (2) @(negedge clk1x);
      chk("orphan_din", {16'd0, ioctl_din}, 32'd0);
      chk("orphan_wait", {31'd0, ioctl_wait}, 32'd0);
      chk("orphan_req", {31'd0, mem_req}, 32'd0);
      chk("orphan_reqs", reqs, r0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
